fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream drain stage for the 8-bit FIFO. It pops one byte at a time through the FIFO's `rd`/`empty`/`data_out` port and serializes each byte as an asynchronous UART frame: start bit, 8 data bits LSB first, optional even parity, one stop bit. It sits between the FIFO read side and the board TX pin. It never reads an empty FIFO, so the FIFO's underflow flag stays low.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range ≥ 2.
- `PARITY_EN`, 0: when 1, an even-parity bit is inserted between D7 and the stop bit.
- `clk` in 1: single clock; every register in the block is clocked on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tx_en` in 1: when high, the block may start a new frame.
- `empty` in 1: FIFO empty flag.
- `data_in` in 8: FIFO `data_out`; valid in the cycle after a cycle with `rd`=1.
- `rd` out 1: FIFO pop request; a one-cycle pulse per byte.
- `tx` out 1: serial line; idle level is 1.
- `busy` out 1: high from the READ state until the stop bit completes.
- `frame_done` out 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
- **FSM states:** IDLE, READ, LOAD, START, DATA, PARITY, STOP.
- **IDLE:** if `tx_en`=1 and `empty`=0 at a clock edge, go to READ. Otherwise stay.
- **READ:** `rd`=1 for exactly this one cycle; go to LOAD.
- **LOAD:** capture `data_in` into `shreg[7:0]` at the end of the cycle.
  - If `PARITY_EN`=1, also capture `par` = XOR of the 8 bits.
  - Go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles; go to DATA.
- **DATA:** `tx`=`shreg[0]`. Each bit is held `CLKS_PER_BIT` cycles, then `shreg` shifts right.
  - A 3-bit bit index counts 0..7.
  - After bit 7, go to PARITY if `PARITY_EN`=1, else STOP.
- **PARITY:** `tx`=`par` for `CLKS_PER_BIT` cycles; go to STOP.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles; `frame_done`=1 in the final cycle; go to IDLE.
- **Baud counter:** width `$clog2(CLKS_PER_BIT)`.
  - Cleared on entry to START, DATA, PARITY and STOP.
  - Counts 0..`CLKS_PER_BIT`-1.
  - The terminal count is the bit-end tick.
- **Outputs:** `rd`, `tx`, `busy` and `frame_done` are registered. They must be glitch-free, with no combinational path from `empty` or `tx_en`.
- **`tx_en` falls mid-frame:** the current frame completes; no new READ is issued.
- **`empty` rises during a frame:** no effect; it is only sampled in IDLE.
- **Reset mid-frame:** `tx` returns to 1 immediately; the popped byte is discarded and not re-read.

## Timing
- **Reset values:** state=IDLE, `tx`=1, `rd`=0, `busy`=0, `frame_done`=0, `shreg`=0, counters=0.
- **Start latency:** `empty`=0 sampled in IDLE at edge k.
  - `rd`=1 in cycle k..k+1.
  - Byte captured at edge k+2.
  - `tx` falls after edge k+2.
- **Frame length:** (10 + `PARITY_EN`) × `CLKS_PER_BIT` cycles from the `tx` falling edge to the end of the stop bit.
- **Back-to-back frames:** the inter-frame gap is 3 cycles of `tx`=1 beyond the stop bit (IDLE, READ, LOAD).
- **Back-to-back rate:** one pop per (10 + `PARITY_EN`) × `CLKS_PER_BIT` + 3 cycles.
- **Pop count:** at most one `rd` pulse per frame. `rd` never asserts while `empty`=1 was sampled.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `tx_state_t` (7 states);
  - `DATA_BITS` = 8;
  - the default `CLKS_PER_BIT`.
- Sub-module `uart_baud_gen`:
  - parameter `CLKS_PER_BIT`;
  - inputs `clk`, `rst`, `clear`;
  - output `tick` (terminal-count pulse).
- The FSM, shift register, bit index and parity register stay in `fifo_uart_tx`.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `empty`=0.
  - Required: `tx`=1, `rd`=0, `busy`=0 throughout.
  - Required: first `rd` 1 cycle after the edge where `rst` is low and `empty`=0 is sampled.
- **Single byte:** `CLKS_PER_BIT`=4, `PARITY_EN`=0, FIFO holds 0xA5.
  - Required `tx` sequence: 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - Required: exactly one `rd` pulse and one `frame_done` pulse.
- **Back-to-back:** FIFO holds 0x00 then 0xFF, `CLKS_PER_BIT`=4.
  - Required: two frames separated by stop bit + 3 idle cycles.
  - Required: 2 `rd` pulses; `empty` seen at the end.
- **Parity:** `PARITY_EN`=1, byte 0x07.
  - Required: parity bit = 1; frame length 44 cycles at `CLKS_PER_BIT`=4.
- **Flow control:** `tx_en`=0 with a non-empty FIFO; then drop `tx_en` during bit 3 of a frame.
  - Required: no `rd` while `tx_en`=0.
  - Required: the in-flight frame completes; no further `rd`.
- **Reset mid-frame:** assert `rst` during DATA bit 4.
  - Required: `tx`=1 in the same cycle, `busy`=0.
  - Required: after release, the next FIFO byte is transmitted, not the interrupted one.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter.
//   tx_state_t        : transmitter FSM state encoding
//   DATA_BITS         : payload bits per frame
//   DEF_CLKS_PER_BIT  : default clock cycles per serial bit
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FIFO read port, the transmitter and the TX pin.
//   tx_en      : enable starting new frames          (to transmitter)
//   empty      : FIFO empty flag                     (to transmitter)
//   data_in    : FIFO data_out, valid after a rd     (to transmitter)
//   rd         : one-cycle FIFO pop request          (from transmitter)
//   tx         : serial line, idles high             (from transmitter)
//   busy       : frame in progress                   (from transmitter)
//   frame_done : pulse in the last stop-bit cycle    (from transmitter)
// Modports: slave = transmitter side, master = FIFO / system side.
interface fifo_uart_tx_if;
    import uart_pkg::*;

    logic                 tx_en;
    logic                 empty;
    logic [DATA_BITS-1:0] data_in;
    logic                 rd;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    modport slave (
        input  tx_en, empty, data_in,
        output rd, tx, busy, frame_done
    );

    modport master (
        output tx_en, empty, data_in,
        input  rd, tx, busy, frame_done
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; clear forces the count to 0.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   clear    : hold the counter at 0 (used outside the timed states)
//   tick     : terminal count, last cycle of the current bit
//   pre_tick : one cycle before tick, lets the owner register bit-end outputs
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick     = (cnt_q == LAST);
    assign pre_tick = (cnt_q == PRE_LAST);

    // Wrapping at the terminal count restarts the next bit at 0 without the
    // FSM having to pulse clear between consecutive bits.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and sends it as a UART frame
// (start, 8 data bits LSB first, optional even parity, one stop bit).
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : fifo_uart_tx_if.slave (tx_en, empty, data_in in; rd, tx, busy,
//          frame_done out). All outputs come straight from flops.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line idle; wait for tx_en=1 and empty=0
// ST_READ   | rd pulse to the FIFO
// ST_LOAD   | FIFO data valid; capture byte and parity
// ST_START  | start bit (tx=0) for one bit period
// ST_DATA   | data bits, shreg[0] on the line, shift at each bit end
// ST_PARITY | even-parity bit for one bit period
// ST_STOP   | stop bit (tx=1); frame_done in its last cycle
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.slave  bus
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 rd_q, rd_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;

    logic                 baud_clear;
    logic                 tick;
    logic                 pre_tick;

    // Held at zero until the first timed state, so START always begins at 0.
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_READ) ||
                        (state_q == ST_LOAD);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clear),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            par_q        <= par_d;
            tx_q         <= tx_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.tx_en && !bus.empty) begin
                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_START;
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && (bit_idx_q == LAST_BIT)) begin
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        if (state_q == ST_LOAD) begin
            shreg_d   = bus.data_in;
            bit_idx_d = '0;
            par_d     = PARITY_EN ? (^bus.data_in) : 1'b0;
        end else if ((state_q == ST_DATA) && tick) begin
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
        end
    end

    // Outputs are computed from the next state/datapath values so the flops
    // present them in the same cycle the FSM enters the matching state.
    always_comb begin
        rd_d         = (state_d == ST_READ);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_q == ST_STOP) && pre_tick;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign bus.rd         = rd_q;
    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances at CLKS_PER_BIT=4, lane 0 without
// parity and lane 1 with parity, fed identical byte streams. Each lane has a
// FIFO model, an expected-byte queue and a frame monitor.
module tb_fifo_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic tx_en;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   rd0_s = 0, rd1_s = 0, fd0_s = 0, fd1_s = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par_en);
        if (par_en) return {1'b1, ^b, b, 1'b0};
        return {1'b0, 1'b1, b, 1'b0};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LEN = (10 + g) * CPB;

        fifo_uart_tx_if ifc ();

        fifo_uart_tx #(
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (g == 1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );

        logic [7:0]  fifo_q[$];
        logic [7:0]  exp_q[$];
        int          rd_cnt    = 0;
        int          fd_cnt    = 0;
        int          underflow = 0;
        logic [10:0] last_obs  = '0;
        int          end_cyc   = 0;
        bit          had_data  = 1'b0;

        assign ifc.tx_en = tx_en;

        // FIFO model: pop on rd, data_out valid in the following cycle.
        always @(negedge clk) begin
            if (ifc.rd === 1'b1) begin
                rd_cnt++;
                if (fifo_q.size() == 0) underflow++;
                else ifc.data_in = fifo_q.pop_front();
            end
            if (ifc.frame_done === 1'b1) fd_cnt++;
            ifc.empty = (fifo_q.size() == 0);
        end

        always begin : mon
            logic [7:0]  m_eb;
            logic [10:0] m_exp;
            logic [10:0] m_obs;
            int          m_pos;
            int          m_mism;
            int          m_t0;
            bit          m_abort;
            @(negedge clk);
            if (rst === 1'b0 && ifc.tx === 1'b0) begin
                m_t0 = cyc;
                if (had_data) check($sformatf("L%0d gap", g), m_t0 - end_cyc - 1, 3);
                check($sformatf("L%0d exp_avail", g), exp_q.size() > 0, 1);
                m_eb = 8'h00;
                if (exp_q.size() > 0) m_eb = exp_q.pop_front();
                m_exp   = frame_bits(m_eb, g == 1);
                m_obs   = '0;
                m_pos   = -1;
                m_mism  = 0;
                m_abort = 1'b0;
                for (int j = 0; j < LEN; j++) begin
                    if (j > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        m_abort = 1'b1;
                        break;
                    end
                    if (ifc.tx !== m_exp[j / CPB]) m_mism++;
                    if (j % CPB == CPB / 2) m_obs[j / CPB] = ifc.tx;
                    if (ifc.frame_done === 1'b1) m_pos = j;
                end
                had_data = 1'b0;
                if (!m_abort) begin
                    check($sformatf("L%0d frame", g), m_obs, m_exp);
                    check($sformatf("L%0d bit_hold", g), m_mism, 0);
                    check($sformatf("L%0d fdone_pos", g), m_pos, LEN - 1);
                    last_obs = m_obs;
                    end_cyc  = cyc;
                    had_data = (ifc.empty === 1'b0) && (tx_en === 1'b1);
                    @(negedge clk);
                    check($sformatf("L%0d busy_end", g), ifc.busy, 0);
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        lane[0].fifo_q.push_back(b);
        lane[0].exp_q.push_back(b);
        lane[1].fifo_q.push_back(b);
        lane[1].exp_q.push_back(b);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " tx0"},   lane[0].ifc.tx,   1);
        check({tag, " rd0"},   lane[0].ifc.rd,   0);
        check({tag, " busy0"}, lane[0].ifc.busy, 0);
        check({tag, " tx1"},   lane[1].ifc.tx,   1);
        check({tag, " rd1"},   lane[1].ifc.rd,   0);
        check({tag, " busy1"}, lane[1].ifc.busy, 0);
    endtask

    task automatic check_counts(input string tag, input int drd, input int dfd);
        check({tag, " rd_cnt0"}, lane[0].rd_cnt - rd0_s, drd);
        check({tag, " rd_cnt1"}, lane[1].rd_cnt - rd1_s, drd);
        check({tag, " fd_cnt0"}, lane[0].fd_cnt - fd0_s, dfd);
        check({tag, " fd_cnt1"}, lane[1].fd_cnt - fd1_s, dfd);
        rd0_s = lane[0].rd_cnt;
        rd1_s = lane[1].rd_cnt;
        fd0_s = lane[0].fd_cnt;
        fd1_s = lane[1].fd_cnt;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 1000 && !done; i++) begin
            @(posedge clk);
            #1;
            done = !lane[0].ifc.busy && !lane[1].ifc.busy &&
                   lane[0].ifc.empty && lane[1].ifc.empty;
        end
        check(tag, done, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_fall(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (lane[0].ifc.tx == 1'b0);
        end
        check(tag, found, 1);
    endtask

    task automatic wait_not_busy(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            done = !lane[0].ifc.busy && !lane[1].ifc.busy;
        end
        check(tag, done, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        tx_en = 1'b1;
        push(8'hA5);

        // Reset held with a non-empty FIFO, then start latency.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_quiet("reset");
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("latency rd0", lane[0].ifc.rd, 1);
        check("latency rd1", lane[1].ifc.rd, 1);
        @(posedge clk);
        #1;
        check("load rd0", lane[0].ifc.rd, 0);
        check("load tx0", lane[0].ifc.tx, 1);
        @(posedge clk);
        #1;
        check("start tx0", lane[0].ifc.tx, 0);
        check("start tx1", lane[1].ifc.tx, 0);
        wait_idle("single idle");
        check_counts("single", 1, 1);
        check("single byte0", lane[0].last_obs[8:1], 8'hA5);

        // Back-to-back frames.
        push(8'h00);
        push(8'hFF);
        wait_idle("b2b idle");
        check_counts("b2b", 2, 2);
        check("b2b empty0", lane[0].ifc.empty, 1);
        check("b2b empty1", lane[1].ifc.empty, 1);

        // Parity.
        push(8'h07);
        wait_idle("par idle");
        check_counts("par", 1, 1);
        check("par bit", lane[1].last_obs[9], 1);
        check("par frame", lane[1].last_obs, frame_bits(8'h07, 1'b1));
        check("nopar stop", lane[0].last_obs[9], 1);

        // Flow control.
        tx_en = 1'b0;
        push(8'h3C);
        push(8'h5A);
        repeat (20) @(posedge clk);
        #1;
        check_counts("flow off", 0, 0);
        tx_en = 1'b1;
        wait_tx_fall("flow start");
        repeat (17) @(posedge clk);
        #1;
        tx_en = 1'b0;
        wait_not_busy("flow drain");
        repeat (30) @(posedge clk);
        #1;
        check_counts("flow drop", 1, 1);
        check("flow left0", lane[0].ifc.empty, 0);
        check("flow byte0", lane[0].last_obs[8:1], 8'h3C);
        tx_en = 1'b1;
        wait_idle("flow resume idle");
        check_counts("flow resume", 1, 1);
        check("flow byte1", lane[1].last_obs[8:1], 8'h5A);

        // Reset during data bit 4.
        push(8'hC3);
        push(8'h96);
        wait_tx_fall("mid start");
        repeat (21) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid tx0",   lane[0].ifc.tx,   1);
        check("mid busy0", lane[0].ifc.busy, 0);
        check("mid tx1",   lane[1].ifc.tx,   1);
        check("mid busy1", lane[1].ifc.busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_idle("mid idle");
        check_counts("mid", 2, 1);
        check("mid byte0", lane[0].last_obs[8:1], 8'h96);
        check("mid byte1", lane[1].last_obs[8:1], 8'h96);

        check("underflow0", lane[0].underflow, 0);
        check("underflow1", lane[1].underflow, 0);
        check("exp_left0", lane[0].exp_q.size(), 0);
        check("exp_left1", lane[1].exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
